// File: rtl/ro_buffer.sv
// Reorder buffer: in-order retire of out-of-order CDB results, with register status table upkeep.
// Optional ROB_FLUSH_EN adds a flush input and a 31-cycle status-table sweep (SWEEP state).
module ro_buffer #(
  parameter int         DEPTH       = 16,
  parameter logic [5:0] INVALID_TAG = 6'b010000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ROB_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        issue_valid,
  input  logic [4:0]  issue_dest,
  output logic        issue_ready,
  output logic [5:0]  issue_tag,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_value,
  output logic [4:0]  lookup_index,
  input  logic [5:0]  lookup_status,
  output logic        status_we,
  output logic [4:0]  status_index,
  output logic [5:0]  status_data,
  output logic        commit_valid,
  output logic [4:0]  commit_dest,
  output logic [31:0] commit_value,
  output logic [5:0]  commit_tag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d;
  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      val_q  [DEPTH];

  logic        commit_valid_q;
  logic [4:0]  commit_dest_q;
  logic [31:0] commit_value_q;
  logic [5:0]  commit_tag_q;

  logic          run, flush_run, sweeping;
  logic [4:0]    sweep_idx;
  logic          issue_fire, issue_wr, cdb_hit;
  logic [PW-1:0] cdb_idx;
  logic [4:0]    hd_dest;
  logic [5:0]    hd_tag;
  logic          retire_cand, same_dest, need_clear, retire, clear_wr;

`ifdef ROB_FLUSH_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0] state_q, state_d;
  logic [4:0] sweep_idx_q, sweep_idx_d;

  assign run       = (state_q == ST_RUN);
  assign sweeping  = (state_q == ST_SWEEP);
  assign flush_run = run && flush;
  assign sweep_idx = sweep_idx_q;

  // A flush in either state (re)starts the sweep at register 1; r0 never holds a tag.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (flush) begin
      state_d     = ST_SWEEP;
      sweep_idx_d = 5'd1;
    end else if (sweeping) begin
      if (sweep_idx_q == 5'd31) begin
        state_d = ST_RUN;
      end else begin
        sweep_idx_d = sweep_idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      sweep_idx_q <= 5'd1;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end
`else
  assign run       = 1'b1;
  assign sweeping  = 1'b0;
  assign flush_run = 1'b0;
  assign sweep_idx = 5'd0;
`endif

  assign issue_ready  = (count_q < CW'(DEPTH)) && run && !flush_run;
  assign issue_tag    = 6'(tail_q);
  assign issue_fire   = issue_valid && issue_ready;
  assign issue_wr     = issue_fire && (issue_dest != 5'd0);

  assign cdb_idx      = cdb_tag[PW-1:0];
  assign cdb_hit      = cdb_valid && run && (cdb_tag < 6'(DEPTH)) && busy_q[cdb_idx]
                        && !(issue_fire && (cdb_tag == issue_tag));

  assign hd_dest      = dest_q[head_q];
  assign hd_tag       = 6'(head_q);
  assign lookup_index = hd_dest;

  // A same-cycle issue to the head's dest already overwrites the status entry, so no clear is owed.
  assign retire_cand  = run && !flush_run && busy_q[head_q] && done_q[head_q];
  assign same_dest    = issue_fire && (issue_dest == hd_dest);
  assign need_clear   = (hd_dest != 5'd0) && (lookup_status == hd_tag) && !same_dest;
  assign retire       = retire_cand && !(need_clear && issue_wr);
  assign clear_wr     = retire && need_clear;

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (cdb_hit) done_d[cdb_idx] = 1'b1;
    if (retire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
    end
    if (flush_run) begin
      busy_d = '0;
      done_d = '0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (retire) head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    if (issue_fire) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    unique case ({issue_fire, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_run) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Single status write port: sweep, then issue, then retire clear.
  always_comb begin
    status_we    = 1'b0;
    status_index = 5'd0;
    status_data  = 6'd0;
    if (rst) begin
      status_we = 1'b0;
    end else if (sweeping) begin
      status_we    = 1'b1;
      status_index = sweep_idx;
      status_data  = INVALID_TAG;
    end else if (issue_wr) begin
      status_we    = 1'b1;
      status_index = issue_dest;
      status_data  = issue_tag;
    end else if (clear_wr) begin
      status_we    = 1'b1;
      status_index = hd_dest;
      status_data  = INVALID_TAG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= 5'd0;
      commit_value_q <= 32'd0;
      commit_tag_q   <= INVALID_TAG;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      commit_valid_q <= retire;
      if (retire) begin
        commit_dest_q  <= hd_dest;
        commit_value_q <= val_q[head_q];
        commit_tag_q   <= hd_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cdb_hit) val_q[cdb_idx] <= cdb_value;
    if (issue_fire) dest_q[tail_q] <= issue_dest;
  end

  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;

endmodule

// File: tb/tb_ro_buffer.sv
// Scoreboard bench for ro_buffer: status writes and commits are queued at stimulus time and popped by a monitor.
module tb_ro_buffer;
  localparam logic [5:0] INV = 6'b010000;

  logic        clk = 1'b0;
  logic        rst;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic [5:0]  issue_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [4:0]  lookup_index;
  logic [5:0]  lookup_status;
  logic        status_we;
  logic [4:0]  status_index;
  logic [5:0]  status_data;
  logic        commit_valid;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [5:0]  commit_tag;

  always #5 clk = ~clk;

  ro_buffer dut (
    .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .lookup_index(lookup_index), .lookup_status(lookup_status),
    .status_we(status_we), .status_index(status_index), .status_data(status_data),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag)
  );

  // Register status table the buffer maintains.
  logic [5:0] stat [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) stat[i] <= INV;
    end else if (status_we) begin
      stat[status_index] <= status_data;
    end
  end
  assign lookup_status = stat[lookup_index];

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_st [$];
  logic [42:0] exp_cm [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (status_we) begin
        if (exp_st.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL status_write unexpected idx=%0d data=0x%0h at %0t", status_index, status_data, $time);
        end else begin
          chk("status_write", {53'd0, status_index, status_data}, {53'd0, exp_st.pop_front()});
        end
      end
      if (commit_valid) begin
        if (exp_cm.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit unexpected dest=%0d val=0x%0h tag=%0d at %0t", commit_dest, commit_value, commit_tag, $time);
        end else begin
          chk("commit", {21'd0, commit_dest, commit_value, commit_tag}, {21'd0, exp_cm.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [4:0] d, input logic [5:0] t);
    issue_valid = 1'b1;
    issue_dest  = d;
    #1;
    chk("issue_ready", 64'(issue_ready), 64'd1);
    chk("issue_tag", 64'(issue_tag), 64'(t));
    if (d != 5'd0) exp_st.push_back({d, t});
  endtask

  task automatic set_cdb(input logic [5:0] t, input logic [31:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
  endtask

  task automatic push_cm(input logic [4:0] d, input logic [31:0] v, input logic [5:0] t);
    exp_cm.push_back({d, v, t});
  endtask

  initial begin
    rst = 1'b1;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
    issue_valid = 1'b0; issue_dest = 5'd0;
    cdb_valid = 1'b0; cdb_tag = 6'd0; cdb_value = 32'd0;
    tick();
    chk("reset_status_we", 64'(status_we), 64'd0);
    tick();
    chk("reset_commit_valid", 64'(commit_valid), 64'd0);
    chk("reset_commit_tag", 64'(commit_tag), 64'(INV));
    chk("reset_commit_dest", 64'(commit_dest), 64'd0);
    chk("reset_commit_value", 64'(commit_value), 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_issue_ready", 64'(issue_ready), 64'd1);
    chk("reset_issue_tag", 64'(issue_tag), 64'd0);

    // Basic issue, complete, retire with clear.
    set_issue(5'd5, 6'd0); tick(); issue_valid = 1'b0;
    set_cdb(6'd0, 32'hAB); tick(); cdb_valid = 1'b0;
    #1;
    chk("lookup_index", 64'(lookup_index), 64'd5);
    chk("no_same_edge_retire", 64'(commit_valid), 64'd0);
    exp_st.push_back({5'd5, INV});
    push_cm(5'd5, 32'hAB, 6'd0);
    tick(); tick();

    // Fill all 16 entries, tail wraps, 17th request refused.
    for (int i = 0; i < 16; i++) begin
      set_issue(5'(i + 1), 6'((1 + i) % 16));
      tick();
    end
    issue_valid = 1'b1; issue_dest = 5'd20;
    #1;
    chk("full_ready_low", 64'(issue_ready), 64'd0);
    chk("full_tail_wrapped", 64'(issue_tag), 64'd1);
    tick(); issue_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_cdb(6'((1 + i) % 16), 32'(256 + i));
      push_cm(5'(i + 1), 32'(256 + i), 6'((1 + i) % 16));
      exp_st.push_back({5'(i + 1), INV});
      tick();
    end
    cdb_valid = 1'b0;
    tick(); tick();
    chk("drained_ready", 64'(issue_ready), 64'd1);
    chk("drained_tag", 64'(issue_tag), 64'd1);

    // Older producer retires while a newer one owns r3: no clear.
    set_issue(5'd3, 6'd1); tick();
    set_issue(5'd3, 6'd2); tick(); issue_valid = 1'b0;
    set_cdb(6'd1, 32'h39); push_cm(5'd3, 32'h39, 6'd1); tick(); cdb_valid = 1'b0;
    tick();
    set_cdb(6'd2, 32'h3A); exp_st.push_back({5'd3, INV}); push_cm(5'd3, 32'h3A, 6'd2);
    tick(); cdb_valid = 1'b0;
    tick(); tick();

    // Clear of r7 deferred by a concurrent issue write to r9.
    set_issue(5'd7, 6'd3); tick(); issue_valid = 1'b0;
    set_cdb(6'd3, 32'h40); tick(); cdb_valid = 1'b0;
    set_issue(5'd9, 6'd4);
    exp_st.push_back({5'd7, INV});
    push_cm(5'd7, 32'h40, 6'd3);
    tick(); issue_valid = 1'b0;
    #1;
    chk("deferred_no_commit", 64'(commit_valid), 64'd0);
    tick();
    chk("deferred_commit", 64'(commit_valid), 64'd1);
    set_cdb(6'd4, 32'h41); exp_st.push_back({5'd9, INV}); push_cm(5'd9, 32'h41, 6'd4);
    tick(); cdb_valid = 1'b0;
    tick(); tick();

    // Issue and retire to the same dest: retire without clear, no deferral.
    set_issue(5'd6, 6'd5); tick(); issue_valid = 1'b0;
    set_cdb(6'd5, 32'h28); tick(); cdb_valid = 1'b0;
    set_issue(5'd6, 6'd6); push_cm(5'd6, 32'h28, 6'd5);
    tick(); issue_valid = 1'b0;
    #1;
    chk("same_dest_commit", 64'(commit_valid), 64'd1);
    set_cdb(6'd6, 32'h29); exp_st.push_back({5'd6, INV}); push_cm(5'd6, 32'h29, 6'd6);
    tick(); cdb_valid = 1'b0;
    tick(); tick();

    // Ignored CDBs: out of range, idle entry, same-cycle issue tag.
    set_cdb(6'd20, 32'hDEAD); tick();
    set_cdb(6'd9, 32'hBEEF); tick();
    set_issue(5'd0, 6'd7); set_cdb(6'd7, 32'h66); tick();
    issue_valid = 1'b0; cdb_valid = 1'b0;
    tick(); tick(); tick();
    chk("ignored_cdb_no_commit", 64'(commit_valid), 64'd0);
    set_cdb(6'd7, 32'h77); push_cm(5'd0, 32'h77, 6'd7);
    tick(); cdb_valid = 1'b0;
    tick(); tick();

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 4; i++) begin
      set_issue(5'(10 + i), 6'(8 + i));
      tick();
    end
    issue_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 1; i < 32; i++) exp_st.push_back({5'(i), INV});
    for (int i = 1; i < 32; i++) begin
      chk("sweep_ready_low", 64'(issue_ready), 64'd0);
      tick();
    end
    chk("sweep_done_ready", 64'(issue_ready), 64'd1);
    chk("flush_tail_zero", 64'(issue_tag), 64'd0);
    set_cdb(6'd8, 32'h88); tick(); cdb_valid = 1'b0;
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 1; i < 10; i++) exp_st.push_back({5'(i), INV});
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    chk("sweep_reset_no_write", 64'(status_we), 64'd0);
    tick(); rst = 1'b0;
    #1;
    chk("sweep_reset_ready", 64'(issue_ready), 64'd1);
    tick(); tick(); tick();
`endif

    chk("status_queue_empty", 64'(exp_st.size()), 64'd0);
    chk("commit_queue_empty", 64'(exp_cm.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
